// File: rtl/regfile_mp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp_pkg
// Purpose  : Shared defaults and flattened-bus slice helpers for regfile_mp.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_mp_pkg;

    localparam int C_DEFAULT_XLEN  = 32;
    localparam int C_DEFAULT_NREGS = 32;

    // Low bit of port idx inside a bus of width-sized fields packed LSB-first.
    function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_mp_fwd.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp_fwd
// Purpose  : Per-read-port write bypass and busy override (combinational).
//            Active only when REGFILE_MP_BYPASS_EN is defined; else pass-through.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_mp_fwd
    import regfile_mp_pkg::*;
#(
    parameter int XLEN = C_DEFAULT_XLEN,
    parameter int AW   = 5,
    parameter int NWR  = 1
) (
    input  logic [AW-1:0]       i_ra,
    input  logic [XLEN-1:0]     i_rd_reg,
    input  logic                i_busy_reg,
    input  logic [NWR-1:0]      i_we,
    input  logic [NWR*AW-1:0]   i_wa,
    input  logic [NWR*XLEN-1:0] i_wd,
    input  logic                i_bs_en,
    input  logic [AW-1:0]       i_bs_addr,
    output logic [XLEN-1:0]     o_rd,
    output logic                o_rs_busy
);

`ifdef REGFILE_MP_BYPASS_EN
    always_comb begin
        o_rd      = i_rd_reg;
        o_rs_busy = i_busy_reg;
        // Ascending scan: the highest-index matching writer ends up on o_rd.
        for (int i = 0; i < NWR; i++) begin
            if (i_we[i] && (i_wa[slice_lo(i, AW) +: AW] == i_ra) && (i_ra != '0)) begin
                o_rd      = i_wd[slice_lo(i, XLEN) +: XLEN];
                o_rs_busy = i_bs_en && (i_bs_addr == i_ra);
            end
        end
    end
`else
    logic w_unused;

    assign o_rd      = i_rd_reg;
    assign o_rs_busy = i_busy_reg;
    assign w_unused  = ^{i_ra, i_we, i_wa, i_wd, i_bs_en, i_bs_addr};
`endif

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Purpose  : Multi-port integer register file with x0 hardwired to zero and a
//            per-register busy scoreboard. Optional bypass: REGFILE_MP_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int XLEN  = C_DEFAULT_XLEN,
    parameter int NREGS = C_DEFAULT_NREGS,
    parameter int NRD   = 2,
    parameter int NWR   = 1,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NWR-1:0]      we,
    input  logic [NWR*AW-1:0]   wa,
    input  logic [NWR*XLEN-1:0] wd,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    input  logic                bs_en,
    input  logic [AW-1:0]       bs_addr,
    output logic [NRD-1:0]      rs_busy
);

    logic [XLEN-1:0]  r_regs_q [NREGS];
    logic [XLEN-1:0]  w_regs_d [NREGS];
    logic [NREGS-1:0] r_busy_q;
    logic [NREGS-1:0] w_busy_d;

    // Ascending port order lets the highest-index writer win a conflict; the
    // busy set comes after the clears because a new producer supersedes.
    always_comb begin
        w_regs_d = r_regs_q;
        w_busy_d = r_busy_q;
        for (int i = 0; i < NWR; i++) begin
            if (we[i] && (wa[slice_lo(i, AW) +: AW] != '0)) begin
                w_regs_d[wa[slice_lo(i, AW) +: AW]] = wd[slice_lo(i, XLEN) +: XLEN];
                w_busy_d[wa[slice_lo(i, AW) +: AW]] = 1'b0;
            end
        end
        if (bs_en && (bs_addr != '0)) begin
            w_busy_d[bs_addr] = 1'b1;
        end
        w_regs_d[0] = '0;
        w_busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NREGS; k++) begin
                r_regs_q[k] <= '0;
            end
            r_busy_q <= '0;
        end else begin
            r_regs_q <= w_regs_d;
            r_busy_q <= w_busy_d;
        end
    end

    for (genvar j = 0; j < NRD; j++) begin : g_rd
        logic [AW-1:0]   w_addr;
        logic [XLEN-1:0] w_rd_reg;
        logic            w_busy_reg;

        assign w_addr     = ra[slice_lo(j, AW) +: AW];
        assign w_rd_reg   = (w_addr == '0) ? '0 : r_regs_q[w_addr];
        assign w_busy_reg = (w_addr != '0) && r_busy_q[w_addr];

        regfile_mp_fwd #(
            .XLEN (XLEN),
            .AW   (AW),
            .NWR  (NWR)
        ) u_fwd (
            .i_ra       (w_addr),
            .i_rd_reg   (w_rd_reg),
            .i_busy_reg (w_busy_reg),
            .i_we       (we),
            .i_wa       (wa),
            .i_wd       (wd),
            .i_bs_en    (bs_en),
            .i_bs_addr  (bs_addr),
            .o_rd       (rd[slice_lo(j, XLEN) +: XLEN]),
            .o_rs_busy  (rs_busy[j])
        );
    end

endmodule
`default_nettype wire
